// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin sequencer that lets two requesters share one
// external up/down counter. A granted job loads the counter with its start
// value, steps it len times in the requested direction, then returns the
// counter value to the owner with a one-cycle done pulse.
//
// Optional build macro CNT_ARB_CHECK_EN adds the cnt_err output, which flags
// a DONE-cycle counter value that differs from (start +/- len) mod 2^WIDTH.
module counter_arbiter #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req,
  input  logic [2*WIDTH-1:0]   req_start,
  input  logic [2*LEN_W-1:0]   req_len,
  input  logic [1:0]           req_dir,
  output logic [1:0]           gnt,
  output logic [1:0]           done,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic [WIDTH-1:0]     cnt_data_in,
  output logic                 cnt_load,
  output logic                 cnt_enable,
  output logic                 cnt_up_down,
  input  logic [WIDTH-1:0]     cnt_data_out
`ifdef CNT_ARB_CHECK_EN
  ,
  output logic                 cnt_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         done_q, done_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   cnt_data_in_q, cnt_data_in_d;
  logic               cnt_load_q, cnt_load_d;
  logic               cnt_enable_q, cnt_enable_d;
  logic               cnt_up_down_q, cnt_up_down_d;
  logic               prio_q, prio_d;
  logic               owner_q, owner_d;
  logic [WIDTH-1:0]   start_q, start_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               dir_q, dir_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;

  logic               arb_en_s;
  logic               prio_eff_s;
  logic               win_s;

`ifdef CNT_ARB_CHECK_EN
  // Expected counter value at completion, evaluated wide so that the
  // subtraction wraps exactly like the counter does modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] job_result(
    input logic [WIDTH-1:0] start,
    input logic [LEN_W-1:0] len,
    input logic             up
  );
    logic [WIDTH+LEN_W-1:0] s_w;
    logic [WIDTH+LEN_W-1:0] l_w;
    logic [WIDTH+LEN_W-1:0] r_w;
    s_w = {{LEN_W{1'b0}}, start};
    l_w = {{WIDTH{1'b0}}, len};
    if (up) begin
      r_w = s_w + l_w;
    end else begin
      r_w = s_w - l_w;
    end
    return r_w[WIDTH-1:0];
  endfunction
`endif

  // Round-robin pick: in DONE the pointer is about to flip, so use the
  // flipped value to keep back-to-back grants fair.
  always_comb begin
    if (state_q == ST_DONE) begin
      prio_eff_s = ~owner_q;
    end else begin
      prio_eff_s = prio_q;
    end
    if (req == 2'b11) begin
      win_s = prio_eff_s;
    end else begin
      win_s = req[1];
    end
  end

  // Next-state, job capture and grant decision.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    start_d     = start_q;
    len_d       = len_q;
    dir_d       = dir_q;
    gnt_d       = 2'b00;
    arb_en_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // gnt_q set means the job was accepted last edge; start it now.
        if (gnt_q != 2'b00) begin
          state_d = ST_LOAD;
        end else if (req != 2'b00) begin
          arb_en_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        remaining_d = len_q;
        if (len_q == {LEN_W{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        remaining_d = remaining_q - LEN_W'(1);
        if (remaining_q <= LEN_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_DONE: begin
        prio_d  = ~owner_q;
        state_d = ST_IDLE;
        // Accepting here lets the next gnt land in the first IDLE cycle.
        if (req != 2'b00) begin
          arb_en_s = 1'b1;
        end else begin
          arb_en_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (arb_en_s) begin
      gnt_d   = win_s ? 2'b10 : 2'b01;
      owner_d = win_s;
      start_d = win_s ? req_start[WIDTH +: WIDTH] : req_start[0 +: WIDTH];
      len_d   = win_s ? req_len[LEN_W +: LEN_W] : req_len[0 +: LEN_W];
      dir_d   = win_s ? req_dir[1] : req_dir[0];
    end else begin
      gnt_d   = 2'b00;
    end
  end

  // Output next values decoded from the next state so outputs come from flops.
  always_comb begin
    busy_d        = (gnt_d != 2'b00) || (state_d != ST_IDLE);
    cnt_load_d    = (state_d == ST_LOAD);
    cnt_enable_d  = (state_d == ST_COUNT);
    if (state_d == ST_LOAD) begin
      cnt_data_in_d = start_d;
    end else begin
      cnt_data_in_d = {WIDTH{1'b0}};
    end
    if (state_d == ST_COUNT) begin
      cnt_up_down_d = dir_d;
    end else begin
      cnt_up_down_d = 1'b0;
    end
    if (state_d == ST_DONE) begin
      done_d = owner_d ? 2'b10 : 2'b01;
    end else begin
      done_d = 2'b00;
    end
  end

  // State, captured job and registered outputs; reset aborts any job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      gnt_q         <= 2'b00;
      done_q        <= 2'b00;
      busy_q        <= 1'b0;
      cnt_data_in_q <= {WIDTH{1'b0}};
      cnt_load_q    <= 1'b0;
      cnt_enable_q  <= 1'b0;
      cnt_up_down_q <= 1'b0;
      prio_q        <= 1'b0;
      owner_q       <= 1'b0;
      start_q       <= {WIDTH{1'b0}};
      len_q         <= {LEN_W{1'b0}};
      dir_q         <= 1'b0;
      remaining_q   <= {LEN_W{1'b0}};
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      cnt_data_in_q <= cnt_data_in_d;
      cnt_load_q    <= cnt_load_d;
      cnt_enable_q  <= cnt_enable_d;
      cnt_up_down_q <= cnt_up_down_d;
      prio_q        <= prio_d;
      owner_q       <= owner_d;
      start_q       <= start_d;
      len_q         <= len_d;
      dir_q         <= dir_d;
      remaining_q   <= remaining_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign cnt_data_in = cnt_data_in_q;
  assign cnt_load    = cnt_load_q;
  assign cnt_enable  = cnt_enable_q;
  assign cnt_up_down = cnt_up_down_q;

  // The counter settles on its final value during DONE, so result is the
  // counter output gated by the DONE state flop rather than a re-registered copy.
  assign result = (state_q == ST_DONE) ? cnt_data_out : {WIDTH{1'b0}};

`ifdef CNT_ARB_CHECK_EN
  assign cnt_err = (state_q == ST_DONE) &&
                   (cnt_data_out != job_result(start_q, len_q, dir_q));
`endif

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter: behavioural counter, timeline
// reference model, directed scenarios and randomized two-requester traffic.
module tb_counter_arbiter;

  localparam int MAXC = 4096;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [7:0]  st [2];
  logic [7:0]  ln [2];
  logic        dr [2];
  logic [15:0] req_start;
  logic [15:0] req_len;
  logic [1:0]  req_dir;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [7:0]  result;
  logic        busy;
  logic [7:0]  cnt_data_in;
  logic        cnt_load;
  logic        cnt_enable;
  logic        cnt_up_down;
  logic [7:0]  cnt_data_out;
`ifdef CNT_ARB_CHECK_EN
  logic        cnt_err;
`endif

  assign req_start = {st[1], st[0]};
  assign req_len   = {ln[1], ln[0]};
  assign req_dir   = {dr[1], dr[0]};

  counter_arbiter #(.WIDTH(8), .LEN_W(8)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .req          (req),
    .req_start    (req_start),
    .req_len      (req_len),
    .req_dir      (req_dir),
    .gnt          (gnt),
    .done         (done),
    .result       (result),
    .busy         (busy),
    .cnt_data_in  (cnt_data_in),
    .cnt_load     (cnt_load),
    .cnt_enable   (cnt_enable),
    .cnt_up_down  (cnt_up_down),
    .cnt_data_out (cnt_data_out)
`ifdef CNT_ARB_CHECK_EN
    ,
    .cnt_err      (cnt_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared counter: load wins over enable, steps wrap mod 256.
  logic [7:0] cnt_val = 8'd0;
  logic       force_zero = 1'b0;
  always @(posedge clk) begin
    if (cnt_load) cnt_val <= cnt_data_in;
    else if (cnt_enable) cnt_val <= cnt_up_down ? cnt_val + 8'd1 : cnt_val - 8'd1;
  end
  assign cnt_data_out = force_zero ? 8'd0 : cnt_val;

  // Expected per-cycle output timeline.
  logic [1:0] e_gnt  [MAXC];
  logic [1:0] e_done [MAXC];
  logic [7:0] e_res  [MAXC];
  logic [7:0] e_din  [MAXC];
  bit         e_busy [MAXC];
  bit         e_load [MAXC];
  bit         e_en   [MAXC];
  bit         e_ud   [MAXC];
  bit         e_err  [MAXC];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int free_at = 0;
  int last = 1;
  int gcyc [2];
  int dcyc [2];
  bit pend [2];
  bit auto_drop = 1'b1;
  int obs_gc [$];
  logic [1:0] obs_gv [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < MAXC; k++) begin
      e_gnt[k] = 2'b00; e_done[k] = 2'b00; e_res[k] = 8'd0; e_din[k] = 8'd0;
      e_busy[k] = 1'b0; e_load[k] = 1'b0; e_en[k] = 1'b0; e_ud[k] = 1'b0; e_err[k] = 1'b0;
    end
    free_at = 0;
    last = 1;
    for (int i = 0; i < 2; i++) begin
      gcyc[i] = -10; dcyc[i] = -10; pend[i] = 1'b0;
    end
    obs_gc.delete();
    obs_gv.delete();
  endtask

  // A job granted at cycle t occupies t..t+2+L and ends with (S +/- L) mod 256.
  task automatic model_grant(input int t, input int w);
    int s, l, r;
    bit d;
    s = int'(st[w]); l = int'(ln[w]); d = dr[w];
    r = d ? s + l : s - l;
    r = ((r % 256) + 256) % 256;
    if (t + l + 3 < MAXC) begin
      e_gnt[t] = (w == 1) ? 2'b10 : 2'b01;
      for (int k = t; k <= t + 2 + l; k++) e_busy[k] = 1'b1;
      e_load[t + 1] = 1'b1;
      e_din[t + 1] = st[w];
      for (int k = t + 2; k <= t + 1 + l; k++) begin
        e_en[k] = 1'b1;
        e_ud[k] = d;
      end
      e_done[t + 2 + l] = (w == 1) ? 2'b10 : 2'b01;
      e_res[t + 2 + l] = 8'(r);
    end
    free_at = t + 3 + l;
    last = w;
    pend[w] = 1'b0;
    gcyc[w] = t;
    dcyc[w] = t + 2 + l;
  endtask

  // One clock: model arbitrates on the req seen at the edge, then every
  // output is compared with the timeline.
  task automatic step();
    logic [1:0] rq;
    logic rs;
    int w;
    rq = req;
    rs = rst_n;
    @(posedge clk);
    #1;
    cyc++;
    if (rs && rst_n && cyc >= free_at && rq != 2'b00) begin
      if (rq == 2'b11) w = 1 - last;
      else w = rq[1] ? 1 : 0;
      model_grant(cyc, w);
    end
    check_eq("gnt", 32'(gnt), 32'(e_gnt[cyc]));
    check_eq("done", 32'(done), 32'(e_done[cyc]));
    check_eq("result", 32'(result), 32'(e_res[cyc]));
    check_eq("busy", 32'(busy), 32'(e_busy[cyc]));
    check_eq("load", 32'(cnt_load), 32'(e_load[cyc]));
    check_eq("data_in", 32'(cnt_data_in), 32'(e_din[cyc]));
    check_eq("enable", 32'(cnt_enable), 32'(e_en[cyc]));
    check_eq("up_down", 32'(cnt_up_down), 32'(e_ud[cyc]));
`ifdef CNT_ARB_CHECK_EN
    check_eq("cnt_err", 32'(cnt_err), 32'(e_err[cyc]));
`endif
    if (gnt != 2'b00) begin
      obs_gc.push_back(cyc);
      obs_gv.push_back(gnt);
    end
    if (auto_drop) begin
      for (int i = 0; i < 2; i++) begin
        if (req[i] && gcyc[i] == cyc - 1) req[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_gnt"}, 32'(gnt), 32'd0);
    check_eq({pfx, "_done"}, 32'(done), 32'd0);
    check_eq({pfx, "_result"}, 32'(result), 32'd0);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
    check_eq({pfx, "_data_in"}, 32'(cnt_data_in), 32'd0);
    check_eq({pfx, "_load"}, 32'(cnt_load), 32'd0);
    check_eq({pfx, "_enable"}, 32'(cnt_enable), 32'd0);
    check_eq({pfx, "_up_down"}, 32'(cnt_up_down), 32'd0);
`ifdef CNT_ARB_CHECK_EN
    check_eq({pfx, "_cnt_err"}, 32'(cnt_err), 32'd0);
`endif
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = 2'b00;
    force_zero = 1'b0;
    model_clear();
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic measure(input int n, output logic [1:0] g0, output int en_cnt,
                         output int ld_cnt, output int d_off,
                         output logic [1:0] d_val, output logic [7:0] r_val);
    int t0;
    t0 = 0; g0 = 2'b00; en_cnt = 0; ld_cnt = 0; d_off = -1; d_val = 2'b00; r_val = 8'd0;
    for (int k = 0; k < n; k++) begin
      step();
      if (k == 0) begin
        t0 = cyc;
        g0 = gnt;
      end
      if (cnt_enable) en_cnt++;
      if (cnt_load) ld_cnt++;
      if (done != 2'b00) begin
        d_off = cyc - t0;
        d_val = done;
        r_val = result;
      end
    end
  endtask

  task automatic agents();
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) begin
        if ($urandom_range(23, 0) == 0) begin
          req[i] = 1'b0;
          pend[i] = 1'b0;
        end
      end else if (!req[i] && cyc > dcyc[i] && $urandom_range(3, 0) == 0) begin
        st[i] = 8'($urandom_range(255, 0));
        ln[i] = ($urandom_range(7, 0) == 0) ? 8'($urandom_range(40, 0)) : 8'($urandom_range(5, 0));
        dr[i] = 1'($urandom_range(1, 0));
        req[i] = 1'b1;
        pend[i] = 1'b1;
      end
    end
  endtask

  initial begin : main
    logic [1:0] g0, dv;
    logic [7:0] rv;
    int en_c, ld_c, doff, t;
    rst_n = 1'b0;
    req = 2'b00;
    for (int i = 0; i < 2; i++) begin
      st[i] = 8'd0; ln[i] = 8'd0; dr[i] = 1'b0;
    end
    apply_reset();

    // Basic up job: 5 + 3 = 8, done five cycles after gnt.
    st[0] = 8'd5; ln[0] = 8'd3; dr[0] = 1'b1; req = 2'b01;
    measure(7, g0, en_c, ld_c, doff, dv, rv);
    check_eq("basic_gnt", 32'(g0), 32'h1);
    check_eq("basic_load_cycles", 32'(ld_c), 32'd1);
    check_eq("basic_enable_cycles", 32'(en_c), 32'd3);
    check_eq("basic_done_latency", 32'(doff), 32'd5);
    check_eq("basic_done", 32'(dv), 32'h1);
    check_eq("basic_result", 32'(rv), 32'd8);

    // Down with wrap: 2 - 4 = 254.
    st[1] = 8'd2; ln[1] = 8'd4; dr[1] = 1'b0; req = 2'b10;
    measure(8, g0, en_c, ld_c, doff, dv, rv);
    check_eq("wrap_gnt", 32'(g0), 32'h2);
    check_eq("wrap_enable_cycles", 32'(en_c), 32'd4);
    check_eq("wrap_done", 32'(dv), 32'h2);
    check_eq("wrap_result", 32'(rv), 32'd254);

    // Zero length: load only, done two cycles after gnt.
    st[0] = 8'h7F; ln[0] = 8'd0; dr[0] = 1'b1; req = 2'b01;
    measure(4, g0, en_c, ld_c, doff, dv, rv);
    check_eq("zero_load_cycles", 32'(ld_c), 32'd1);
    check_eq("zero_enable_cycles", 32'(en_c), 32'd0);
    check_eq("zero_done_latency", 32'(doff), 32'd2);
    check_eq("zero_result", 32'(rv), 32'h7F);

    // Contention from reset, both held high, len=1 each.
    apply_reset();
    auto_drop = 1'b0;
    st[0] = 8'd10; ln[0] = 8'd1; dr[0] = 1'b1;
    st[1] = 8'd20; ln[1] = 8'd1; dr[1] = 1'b0;
    req = 2'b11;
    repeat (16) step();
    req = 2'b00;
    repeat (6) step();
    auto_drop = 1'b1;
    check_eq("cont_grant_count", 32'(obs_gc.size() >= 4), 32'd1);
    if (obs_gc.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check_eq("cont_owner", 32'(obs_gv[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
        if (k > 0) check_eq("cont_spacing", 32'(obs_gc[k] - obs_gc[k - 1]), 32'd4);
      end
    end

    // Reset in the second COUNT cycle of a len=5 job.
    apply_reset();
    st[0] = 8'd10; ln[0] = 8'd5; dr[0] = 1'b1; req = 2'b01;
    repeat (4) step();
    check_eq("mid_enable_before_reset", 32'(cnt_enable), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid");
    apply_reset();
    st[1] = 8'd100; ln[1] = 8'd2; dr[1] = 1'b1; req = 2'b10;
    step();
    check_eq("mid_regrant", 32'(gnt), 32'h2);
    repeat (6) step();

    // Checker: clean job, then forced zero during DONE.
    st[0] = 8'd5; ln[0] = 8'd3; dr[0] = 1'b1; req = 2'b01;
    measure(7, g0, en_c, ld_c, doff, dv, rv);
    check_eq("chk_clean_result", 32'(rv), 32'd8);
    req = 2'b01;
    step();
    t = cyc;
    repeat (4) step();
    force_zero = 1'b1;
    e_res[t + 5] = 8'd0;
    e_err[t + 5] = 1'b1;
    step();
    check_eq("chk_forced_done", 32'(done), 32'h1);
    check_eq("chk_forced_result", 32'(result), 32'd0);
`ifdef CNT_ARB_CHECK_EN
    check_eq("chk_forced_err", 32'(cnt_err), 32'd1);
`endif
    force_zero = 1'b0;
    repeat (3) step();

    // Randomized traffic from both requesters.
    for (int n = 0; n < 1500; n++) begin
      step();
      agents();
    end
    req = 2'b00;
    repeat (60) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
